// File: rtl/softmax_row_feeder.sv
// softmax_row_feeder
// Buffers one softmax row from the streamer, then programs and starts the
// softmax FPU and streams the buffered row into its ext_data port once the
// FPU reports busy. Completion and protocol errors are signalled by one-cycle
// pulses on done_o / err_o.
module softmax_row_feeder #(
    parameter int unsigned DataWidth       = 128,
    parameter int unsigned FP_WIDTH        = 32,
    parameter int unsigned PE_NUM          = DataWidth / FP_WIDTH,
    parameter int unsigned NUM_SOFTMAX_MAX = 128,
    parameter int unsigned BEAT_MAX        = NUM_SOFTMAX_MAX / PE_NUM,
    parameter int unsigned CW              = $clog2(BEAT_MAX) + 1,
    parameter int unsigned START_TIMEOUT   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [5:0]           cfg_func_i,
    input  logic [CW-1:0]        cfg_beats_i,

    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    input  logic [DataWidth-1:0] src_bits_i,

    output logic [31:0]          fpu_csr_o,
    output logic                 fpu_start_o,
    input  logic                 fpu_busy_i,
    output logic                 fpu_data_valid_o,
    input  logic                 fpu_data_ready_i,
    output logic [DataWidth-1:0] fpu_data_bits_o,

    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned AW = $clog2(BEAT_MAX);
    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY = 3'd3;
    localparam logic [2:0] S_SEND      = 3'd4;
    localparam logic [2:0] S_DRAIN     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [31:0]          csr_q, csr_d;
    logic                 err_q, err_d;

    logic [DataWidth-1:0] mem_q [BEAT_MAX];

    logic [CW-1:0]        beats;
    logic [CW-1:0]        beats_m1;
    logic                 cfg_bad;
    logic                 src_hs;

    // The beat count lives inside the CSR word, so it is read back from there.
    assign beats    = csr_q[25 -: CW];
    assign beats_m1 = beats - CW'(1);
    assign cfg_bad  = (cfg_beats_i == '0) || (cfg_beats_i > CW'(BEAT_MAX)) || !cfg_func_i[4];
    assign src_hs   = (state_q == S_FILL) && src_valid_i;

    // Next-state and datapath control for the job sequence.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        csr_d    = csr_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        csr_d    = {cfg_func_i, cfg_beats_i, {(26 - CW){1'b0}}};
                        wr_ptr_d = '0;
                        state_d  = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (src_valid_i) begin
                    wr_ptr_d = wr_ptr_q + CW'(1);
                    if (wr_ptr_q == beats_m1) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d    = '0;
                rd_ptr_d = '0;
                state_d  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                cnt_d = cnt_q + TW'(1);
                if (fpu_busy_i) begin
                    state_d = S_SEND;
                end else if (cnt_q == TW'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                // A busy drop takes precedence over a beat handshake in the same
                // cycle: the FPU has already abandoned the job.
                if (!fpu_busy_i) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (fpu_data_ready_i) begin
                    rd_ptr_d = rd_ptr_q + CW'(1);
                    if (rd_ptr_q == beats_m1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!fpu_busy_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            csr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            csr_q    <= csr_d;
            err_q    <= err_d;
        end
    end

    // Row buffer write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (src_hs) begin
            mem_q[wr_ptr_q[AW-1:0]] <= src_bits_i;
        end
    end

    assign cfg_ready_o      = (state_q == S_IDLE);
    assign src_ready_o      = (state_q == S_FILL);
    assign fpu_start_o      = (state_q == S_START);
    assign fpu_data_valid_o = (state_q == S_SEND);
    assign fpu_data_bits_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign fpu_csr_o        = csr_q;
    assign done_o           = (state_q == S_DONE);
    assign err_o            = err_q;

endmodule
